// File: rtl/seg7_scan_driver.sv
// Three-digit 7-segment scan driver: per-frame digit snapshot, prescaled
// one-hot digit scan, dash/blank codes and leading-zero blanking.
module seg7_scan_driver #(
    parameter int unsigned CLK_DIV        = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          LZB            = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_done
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    typedef enum logic [1:0] {
        S_HUND,
        S_ONES,
        S_TENS
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_hund;
    logic [3:0]    r_tens;
    logic [6:0]    r_seg;
    logic [2:0]    r_an;
    logic          r_fd;

    logic          w_tick;
    logic [3:0]    w_digit;
    logic          w_blank;
    logic [2:0]    w_an;
    logic [6:0]    w_pat;
    logic [6:0]    w_seg;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b0111111;
            4'd1:    p = 7'b0000110;
            4'd2:    p = 7'b1011011;
            4'd3:    p = 7'b1001111;
            4'd4:    p = 7'b1100110;
            4'd5:    p = 7'b1101101;
            4'd6:    p = 7'b1111101;
            4'd7:    p = 7'b0000111;
            4'd8:    p = 7'b1111111;
            4'd9:    p = 7'b1101111;
            4'd10:   p = 7'b1000000;
            default: p = 7'b0000000;
        endcase
        return p;
    endfunction

    assign w_tick = (r_cnt == LAST);

    // Next slot's content; the ones slot opens a frame, so it reads the live input
    always_comb begin
        w_state_nxt = S_ONES;
        w_digit     = ones;
        w_blank     = 1'b0;
        w_an        = 3'b001;
        case (r_state)
            S_HUND: begin
                w_state_nxt = S_ONES;
                w_digit     = ones;
                w_an        = 3'b001;
            end
            S_ONES: begin
                w_state_nxt = S_TENS;
                w_digit     = r_tens;
                w_an        = 3'b010;
                w_blank     = LZB && (r_tens == 4'd0) &&
                              ((r_hund == 4'd0) || (r_hund >= 4'd11));
            end
            S_TENS: begin
                w_state_nxt = S_HUND;
                w_digit     = r_hund;
                w_an        = 3'b100;
                w_blank     = LZB && (r_hund == 4'd0);
            end
            default: begin
                w_state_nxt = S_HUND;
                w_an        = 3'b000;
                w_blank     = 1'b1;
            end
        endcase
        w_pat = w_blank ? 7'b0000000 : decode(w_digit);
        w_seg = SEG_ACTIVE_LOW ? ~w_pat : w_pat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_state <= S_HUND;
            r_hund  <= 4'd11;
            r_tens  <= 4'd11;
            r_seg   <= SEG_OFF;
            r_an    <= 3'b000;
            r_fd    <= 1'b0;
        end else begin
            r_fd <= w_tick && (r_state == S_HUND);
            if (w_tick) begin
                r_cnt   <= '0;
                r_state <= w_state_nxt;
                if (r_state == S_HUND) begin
                    r_hund <= hundreds;
                    r_tens <= tens;
                end
                r_seg <= enable ? w_seg : SEG_OFF;
                r_an  <= enable ? w_an : 3'b000;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_done = r_fd;

endmodule
